// File: rtl/rca_config_loader.sv
// rca_config_loader
// Streams the fixed-order configuration words of one accelerator slot into the
// RCA configuration register file. Each accepted word becomes a one-cycle write
// strobe with address and value on the port of the section currently being
// loaded: grid muxes, IO muxes, feedback result muxes, then the IO input map.
module rca_config_loader #(
    parameter int NUM_RCAS           = 4,
    parameter int NUM_GRID_MUXES     = 8,
    parameter int GRID_MUX_INPUTS    = 8,
    parameter int GRID_NUM_ROWS      = 4,
    parameter int IO_UNIT_MUX_INPUTS = 8,
    parameter int NUM_WRITE_PORTS    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(NUM_RCAS)-1:0]            start_rca,
    input  logic [31:0]                            cfg_data,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    output logic [$clog2(NUM_RCAS)-1:0]            rca_sel_cfg,
    output logic                                   grid_mux_wr_en,
    output logic [$clog2(NUM_GRID_MUXES)-1:0]      grid_mux_wr_addr,
    output logic [$clog2(GRID_MUX_INPUTS)-1:0]     new_grid_mux_sel,
    output logic                                   io_mux_wr_en,
    output logic [$clog2(GRID_NUM_ROWS)-1:0]       io_mux_addr,
    output logic [$clog2(IO_UNIT_MUX_INPUTS)-1:0]  new_io_mux_sel,
    output logic                                   rca_fb_result_mux_wr_en,
    output logic [$clog2(NUM_WRITE_PORTS)-1:0]     rca_result_mux_addr,
    output logic [$clog2(GRID_NUM_ROWS)-1:0]       new_rca_result_mux_sel,
    output logic                                   rca_io_inp_map_wr_en,
    output logic [GRID_NUM_ROWS-1:0]               new_rca_io_inp_map,
    output logic                                   busy,
    output logic                                   done
);

    localparam int GA_W = $clog2(NUM_GRID_MUXES);
    localparam int GS_W = $clog2(GRID_MUX_INPUTS);
    localparam int IA_W = $clog2(GRID_NUM_ROWS);
    localparam int IS_W = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RA_W = $clog2(NUM_WRITE_PORTS);
    localparam int RS_W = $clog2(GRID_NUM_ROWS);

    // The word index must cover the longest addressed section.
    localparam int MAX_GI  = (NUM_GRID_MUXES > GRID_NUM_ROWS) ? NUM_GRID_MUXES : GRID_NUM_ROWS;
    localparam int MAX_SEC = (MAX_GI > NUM_WRITE_PORTS) ? MAX_GI : NUM_WRITE_PORTS;
    localparam int IDX_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

    localparam logic [IDX_W-1:0] GRID_LAST = IDX_W'(NUM_GRID_MUXES - 1);
    localparam logic [IDX_W-1:0] IO_LAST   = IDX_W'(GRID_NUM_ROWS - 1);
    localparam logic [IDX_W-1:0] RES_LAST  = IDX_W'(NUM_WRITE_PORTS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GRID = 3'd1,
        S_IO   = 3'd2,
        S_RES  = 3'd3,
        S_MAP  = 3'd4
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;

    // High bits of the config word carry nothing for this loader.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data;

    // Handshake and status are pure decodes of the state register.
    assign cfg_ready = (state_reg != S_IDLE);
    assign busy      = (state_reg != S_IDLE);

    // Section sequencer: one registered write per accepted word, strobes default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg               <= S_IDLE;
            idx_reg                 <= '0;
            rca_sel_cfg             <= '0;
            grid_mux_wr_en          <= 1'b0;
            grid_mux_wr_addr        <= '0;
            new_grid_mux_sel        <= '0;
            io_mux_wr_en            <= 1'b0;
            io_mux_addr             <= '0;
            new_io_mux_sel          <= '0;
            rca_fb_result_mux_wr_en <= 1'b0;
            rca_result_mux_addr     <= '0;
            new_rca_result_mux_sel  <= '0;
            rca_io_inp_map_wr_en    <= 1'b0;
            new_rca_io_inp_map      <= '0;
            done                    <= 1'b0;
        end else begin
            grid_mux_wr_en          <= 1'b0;
            io_mux_wr_en            <= 1'b0;
            rca_fb_result_mux_wr_en <= 1'b0;
            rca_io_inp_map_wr_en    <= 1'b0;
            done                    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        rca_sel_cfg <= start_rca;
                        idx_reg     <= '0;
                        state_reg   <= S_GRID;
                    end
                end
                S_GRID: begin
                    if (cfg_valid) begin
                        grid_mux_wr_en   <= 1'b1;
                        grid_mux_wr_addr <= idx_reg[GA_W-1:0];
                        new_grid_mux_sel <= cfg_data[GS_W-1:0];
                        if (idx_reg == GRID_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= S_IO;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                S_IO: begin
                    if (cfg_valid) begin
                        io_mux_wr_en   <= 1'b1;
                        io_mux_addr    <= idx_reg[IA_W-1:0];
                        new_io_mux_sel <= cfg_data[IS_W-1:0];
                        if (idx_reg == IO_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= S_RES;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                S_RES: begin
                    if (cfg_valid) begin
                        rca_fb_result_mux_wr_en <= 1'b1;
                        rca_result_mux_addr     <= idx_reg[RA_W-1:0];
                        new_rca_result_mux_sel  <= cfg_data[RS_W-1:0];
                        if (idx_reg == RES_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= S_MAP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                S_MAP: begin
                    // Single word; done rides with the map strobe while already back in IDLE.
                    if (cfg_valid) begin
                        rca_io_inp_map_wr_en <= 1'b1;
                        new_rca_io_inp_map   <= cfg_data[GRID_NUM_ROWS-1:0];
                        done                 <= 1'b1;
                        idx_reg              <= '0;
                        state_reg            <= S_IDLE;
                    end
                end
                default: begin
                    idx_reg   <= '0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_config_loader.sv
// Testbench for rca_config_loader: random config streams checked against a
// word-count based model of the load sequence.
module tb_rca_config_loader;

    localparam int NG  = 8;
    localparam int NIO = 4;
    localparam int NW  = 2;
    localparam int NWORDS = NG + NIO + NW + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  start_rca = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  rca_sel_cfg;
    logic        grid_mux_wr_en;
    logic [2:0]  grid_mux_wr_addr;
    logic [2:0]  new_grid_mux_sel;
    logic        io_mux_wr_en;
    logic [1:0]  io_mux_addr;
    logic [2:0]  new_io_mux_sel;
    logic        rca_fb_result_mux_wr_en;
    logic        rca_result_mux_addr;
    logic [1:0]  new_rca_result_mux_sel;
    logic        rca_io_inp_map_wr_en;
    logic [3:0]  new_rca_io_inp_map;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    rca_config_loader dut (
        .clk(clk), .rst(rst), .start(start), .start_rca(start_rca),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .rca_sel_cfg(rca_sel_cfg),
        .grid_mux_wr_en(grid_mux_wr_en), .grid_mux_wr_addr(grid_mux_wr_addr),
        .new_grid_mux_sel(new_grid_mux_sel),
        .io_mux_wr_en(io_mux_wr_en), .io_mux_addr(io_mux_addr),
        .new_io_mux_sel(new_io_mux_sel),
        .rca_fb_result_mux_wr_en(rca_fb_result_mux_wr_en),
        .rca_result_mux_addr(rca_result_mux_addr),
        .new_rca_result_mux_sel(new_rca_result_mux_sel),
        .rca_io_inp_map_wr_en(rca_io_inp_map_wr_en),
        .new_rca_io_inp_map(new_rca_io_inp_map),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: load in progress flag, word number within the load, expected outputs.
    bit          m_busy = 1'b0;
    int          m_n = 0;
    logic [1:0]  e_sel = '0;
    logic        e_gen = 1'b0;
    logic [2:0]  e_gaddr = '0;
    logic [2:0]  e_gsel = '0;
    logic        e_ien = 1'b0;
    logic [1:0]  e_iaddr = '0;
    logic [2:0]  e_isel = '0;
    logic        e_ren = 1'b0;
    logic        e_raddr = 1'b0;
    logic [1:0]  e_rsel = '0;
    logic        e_men = 1'b0;
    logic [3:0]  e_map = '0;
    logic        e_done = 1'b0;

    function automatic logic [26:0] obs();
        return {rca_sel_cfg, grid_mux_wr_en, grid_mux_wr_addr, new_grid_mux_sel,
                io_mux_wr_en, io_mux_addr, new_io_mux_sel,
                rca_fb_result_mux_wr_en, rca_result_mux_addr, new_rca_result_mux_sel,
                rca_io_inp_map_wr_en, new_rca_io_inp_map, busy, done, cfg_ready};
    endfunction

    function automatic logic [26:0] expv();
        return {e_sel, e_gen, e_gaddr, e_gsel, e_ien, e_iaddr, e_isel,
                e_ren, e_raddr, e_rsel, e_men, e_map, m_busy, e_done, m_busy};
    endfunction

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic [1:0] ra,
                        input logic v, input logic [31:0] d);
        rst = r; start = s; start_rca = ra; cfg_valid = v; cfg_data = d;
        if (r) begin
            m_busy = 1'b0; m_n = 0; e_sel = '0;
            e_gen = 0; e_gaddr = '0; e_gsel = '0;
            e_ien = 0; e_iaddr = '0; e_isel = '0;
            e_ren = 0; e_raddr = '0; e_rsel = '0;
            e_men = 0; e_map = '0; e_done = 0;
        end else begin
            e_gen = 0; e_ien = 0; e_ren = 0; e_men = 0; e_done = 0;
            if (!m_busy) begin
                if (s) begin
                    e_sel = ra; m_busy = 1'b1; m_n = 0;
                end
            end else if (v) begin
                if (m_n < NG) begin
                    e_gen = 1; e_gaddr = 3'(m_n); e_gsel = d[2:0];
                end else if (m_n < NG + NIO) begin
                    e_ien = 1; e_iaddr = 2'(m_n - NG); e_isel = d[2:0];
                end else if (m_n < NG + NIO + NW) begin
                    e_ren = 1; e_raddr = 1'(m_n - NG - NIO); e_rsel = d[1:0];
                end else begin
                    e_men = 1; e_map = d[3:0]; e_done = 1; m_busy = 1'b0;
                end
                m_n = m_busy ? m_n + 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'(i), 1'b1, $urandom);
            if (obs() !== 27'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h want 0", i, obs());
            end
            checks++;
        end
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs(), expv());
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 2'd2, 1'b0, 32'd0);
        for (int i = 1; i <= NWORDS; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, 32'(i - 1));
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL b2b word%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
            if (done !== (i == NWORDS)) begin
                errors++;
                $display("FAIL b2b_done word%0d: got %b want %b", i, done, (i == NWORDS));
            end
            checks++;
        end
        if (rca_sel_cfg !== 2'd2 || new_rca_io_inp_map !== 4'hE) begin
            errors++;
            $display("FAIL b2b_final: sel %0d map %h want 2 e", rca_sel_cfg, new_rca_io_inp_map);
        end
        checks++;
        step(1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic test_stall();
        int acc = 0;
        int strobes = 0;
        int dones = 0;
        int cyc = 0;
        step(1'b0, 1'b1, 2'($urandom), 1'b0, 32'd0);
        while (acc < NWORDS && cyc < 200) begin
            logic v;
            v = (cyc % 2 == 0);
            step(1'b0, 1'b0, 2'd0, v, $urandom);
            if (v) acc++;
            strobes += grid_mux_wr_en + io_mux_wr_en + rca_fb_result_mux_wr_en + rca_io_inp_map_wr_en;
            dones += done;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL stall cyc%0d: got %h want %h", cyc, obs(), expv());
            end
            checks++;
            cyc++;
        end
        if (strobes !== NWORDS || dones !== 1) begin
            errors++;
            $display("FAIL stall_counts: strobes %0d dones %0d want %0d 1", strobes, dones, NWORDS);
        end
        checks++;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, $urandom);
            if (obs() !== expv() || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cyc%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
        end
        step(1'b0, 1'b1, 2'd3, 1'b0, 32'd0);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b0, (i < 4), 2'd0, 1'b1, $urandom);
            if (obs() !== expv() || rca_sel_cfg !== 2'd3) begin
                errors++;
                $display("FAIL midload_start word%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_rst_mid();
        step(1'b0, 1'b1, 2'($urandom), 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 1'b1, $urandom);
        step(1'b1, 1'b0, 2'd0, 1'b1, $urandom);
        if (obs() !== 27'd0) begin
            errors++;
            $display("FAIL rst_mid: got %h want 0", obs());
        end
        checks++;
        step(1'b0, 1'b1, 2'd1, 1'b0, 32'd0);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, $urandom);
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rst_reload word%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back_restart();
        step(1'b0, 1'b1, 2'd0, 1'b0, 32'd0);
        for (int i = 0; i < NWORDS; i++) step(1'b0, 1'b0, 2'd0, 1'b1, $urandom);
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: done %b busy %b want 1 0", done, busy);
        end
        checks++;
        step(1'b0, 1'b1, 2'd1, 1'b0, 32'd0);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, $urandom);
            if (obs() !== expv() || rca_sel_cfg !== 2'd1) begin
                errors++;
                $display("FAIL restart word%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_all_ones();
        step(1'b0, 1'b1, 2'($urandom), 1'b0, 32'd0);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF);
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL ones word%0d: got %h want %h", i, obs(), expv());
            end
            checks++;
        end
        if (new_grid_mux_sel !== 3'd7 || new_io_mux_sel !== 3'd7 ||
            new_rca_result_mux_sel !== 2'd3 || new_rca_io_inp_map !== 4'hF ||
            grid_mux_wr_addr !== 3'd7 || io_mux_addr !== 2'd3 || rca_result_mux_addr !== 1'b1) begin
            errors++;
            $display("FAIL ones_final: got %h want sels 7 7 3 f addrs 7 3 1", obs());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_idle_ignore();
        test_rst_mid();
        test_back_to_back_restart();
        test_all_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
